// File: rtl/apo_node_injector_if.sv
// Host/router-facing signal bundle for the circulant node injector.
// The master side (host, router model) drives requests and link state; the slave side is the injector.
interface apo_node_injector_if;
  logic [7:0]  router_name;
  logic        req_valid;
  logic [7:0]  req_dest;
  logic        req_ready;
  logic [3:0]  link_valid;
  logic [16:0] out_free;
  logic        out_data;
  logic        bad_dest;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [7:0]  coll_count;

  modport master (
    output router_name, req_valid, req_dest, link_valid, out_data,
    input  req_ready, out_free, bad_dest, tx_count, rx_count, coll_count
  );

  modport slave (
    input  router_name, req_valid, req_dest, link_valid, out_data,
    output req_ready, out_free, bad_dest, tx_count, rx_count, coll_count
  );
endinterface

// File: rtl/apo_node_injector.sv
// Node injector: queues host destinations and injects them into the router's free slot
// when transit links are idle, forcing injection after a bounded starvation period.
module apo_node_injector #(
  parameter int NODES      = 144,
  parameter int DEPTH      = 4,
  parameter int MIN_GAP    = 2,
  parameter int STARVE_LIM = 16
) (
  input logic               clk,
  input logic               rst,
  apo_node_injector_if.slave bus
);

  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int SW       = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
  localparam int GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;
  localparam int GW       = $clog2(GAP_LAST + 2);
  localparam logic [8:0] NODES_LIM = 9'(NODES);

  typedef enum logic [1:0] {IDLE, ARMED, GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [SW-1:0]   starve_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            req_ready_p1;
  logic            bad_dest_p1;
  logic [15:0]     tx_cnt, rx_cnt;
  logic [7:0]      coll_cnt;
  logic            accept, dest_ok, push, pop;
  logic            inject, forced;
  logic [16:0]     out_free_c;
  logic            unused_router;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // router_name only matters to the router's own addressing; local delivery needs no special path.
  assign unused_router = ^bus.router_name;

  assign accept  = bus.req_valid & req_ready_p1;
  assign dest_ok = ({1'b0, bus.req_dest} < NODES_LIM);
  assign push    = accept & dest_ok;
  assign pop     = inject;

  // ---- stage p0: request FIFO and registered handshake ----
  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= bus.req_dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      req_ready_p1 <= 1'b1;
      bad_dest_p1  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      count        <= count_nxt;
      // Ready follows next-cycle occupancy, so a full FIFO never accepts on the cycle it pops.
      req_ready_p1 <= (count_nxt != CW'(DEPTH));
      bad_dest_p1  <= accept & ~dest_ok;
    end
  end

  // ---- stage p0: injection FSM ----
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = ARMED;
      ARMED:   if (inject) state_nxt = GAP;
      GAP:     if (gap_cnt == GW'(GAP_LAST))
                 state_nxt = (count != '0) ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inject     = 1'b0;
    forced     = 1'b0;
    out_free_c = '0;
    if (!rst && state == ARMED && count != '0) begin
      if (bus.link_valid == 4'b0000) begin
        inject = 1'b1;
      end else if (starve_cnt == SW'(STARVE_LIM - 1)) begin
        inject = 1'b1;
        forced = 1'b1;
      end
    end
    if (inject)
      out_free_c = {1'b1, 8'h00, fifo_mem[rd_ptr]};
  end

  always_ff @(posedge clk) begin
    if (rst || state != ARMED || inject)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || state != GAP)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + 1'b1;
  end

  // ---- stage p1: statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      coll_cnt <= '0;
    end else begin
      if (inject)
        tx_cnt <= tx_cnt + 16'd1;
      if (bus.out_data)
        rx_cnt <= rx_cnt + 16'd1;
      if (forced)
        coll_cnt <= sat_inc8(coll_cnt);
    end
  end

  assign bus.req_ready  = req_ready_p1;
  assign bus.bad_dest   = bad_dest_p1 & ~rst;
  assign bus.out_free   = out_free_c;
  assign bus.tx_count   = tx_cnt;
  assign bus.rx_count   = rx_cnt;
  assign bus.coll_count = coll_cnt;

endmodule

// File: tb/tb_apo_node_injector.sv
// Bench for apo_node_injector: directed scenarios plus randomized traffic against a
// queue-based reference that derives each injection time from acceptance and gap rules.
module tb_apo_node_injector;
  localparam int NODES      = 144;
  localparam int DEPTH      = 4;
  localparam int MIN_GAP    = 2;
  localparam int STARVE_LIM = 16;
  localparam int G          = (MIN_GAP > 0) ? MIN_GAP : 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apo_node_injector_if bus();

  apo_node_injector #(
    .NODES(NODES), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: queued destinations with the cycle they were accepted.
  logic [7:0] q_dest[$];
  int         q_acc[$];
  int         cyc = 0;
  int         last_inj;
  int         m_tx, m_rx, m_coll;
  bit         bad_pend;

  logic [16:0] exp_free;
  bit          exp_ready, exp_bad;
  logic [15:0] exp_tx, exp_rx;
  logic [7:0]  exp_coll;

  task automatic model_reset();
    q_dest.delete();
    q_acc.delete();
    last_inj = -1000;
    m_tx = 0; m_rx = 0; m_coll = 0;
    bad_pend = 1'b0;
  endtask

  // One clock cycle: drive inputs after the edge, settle, and compute this cycle's expectations.
  task automatic tick(input bit v, input logic [7:0] d, input logic [3:0] l, input bit od);
    int e;
    bit inj, frc, acc;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid  = v;
    bus.req_dest   = d;
    bus.link_valid = l;
    bus.out_data   = od;
    @(negedge clk);
    exp_ready = (q_dest.size() < DEPTH);
    exp_bad   = bad_pend;
    exp_tx    = 16'(m_tx);
    exp_rx    = 16'(m_rx);
    exp_coll  = 8'(m_coll);
    inj = 1'b0;
    frc = 1'b0;
    if (q_dest.size() > 0) begin
      e = (q_acc[0] + 2 > last_inj + G + 1) ? q_acc[0] + 2 : last_inj + G + 1;
      if (cyc >= e) begin
        if (l == 4'b0000) inj = 1'b1;
        else if (cyc - e == STARVE_LIM - 1) begin inj = 1'b1; frc = 1'b1; end
      end
    end
    exp_free = inj ? {1'b1, 8'h00, q_dest[0]} : 17'h0;
    if (inj) begin
      void'(q_dest.pop_front());
      void'(q_acc.pop_front());
      m_tx++;
      last_inj = cyc;
      if (frc && m_coll < 255) m_coll++;
    end
    if (od) m_rx++;
    acc = v && exp_ready;
    bad_pend = acc && (d >= NODES);
    if (acc && d < NODES) begin
      q_dest.push_back(d);
      q_acc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.out_data   = 1'b0;
    bus.link_valid = 4'b0000;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.out_free !== 17'h0) begin errors++; $display("FAIL reset_free_during: got %h want 0", bus.out_free); end
    checks++;
    if (bus.bad_dest !== 1'b0) begin errors++; $display("FAIL reset_bad_during: got %b want 0", bus.bad_dest); end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    checks++;
    if (bus.out_free !== 17'h0) begin errors++; $display("FAIL reset_free_after: got %h want 0", bus.out_free); end
    checks++;
    if ({bus.tx_count, bus.rx_count, bus.coll_count} !== 40'h0) begin
      errors++; $display("FAIL reset_counters: got tx=%0d rx=%0d coll=%0d want 0", bus.tx_count, bus.rx_count, bus.coll_count);
    end
  endtask

  task automatic test_single_send();
    do_reset();
    bus.router_name = 8'd5;
    tick(1, 8'd37, 4'b0000, 0);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.req_ready); end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.out_free !== 17'h0) begin errors++; $display("FAIL single_early: got %h want 0", bus.out_free); end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.out_free !== 17'h10025) begin errors++; $display("FAIL single_inject: got %h want 10025", bus.out_free); end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.out_free !== 17'h0) begin errors++; $display("FAIL single_once: got %h want 0", bus.out_free); end
    checks++;
    if (bus.tx_count !== 16'd1) begin errors++; $display("FAIL single_tx: got %0d want 1", bus.tx_count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, 8'(10 + i), 4'b0100, 0);
      checks++;
      if (bus.req_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready[%0d]: got %b want %b", i, bus.req_ready, (i < 4)); end
      checks++;
      if (bus.out_free !== 17'h0) begin errors++; $display("FAIL fill_free[%0d]: got %h want 0", i, bus.out_free); end
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 8'd0, 4'b0100, 0);
      checks++;
      if (bus.out_free !== 17'h0 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL fill_hold[%0d]: got free=%h ready=%b want 0/0", i, bus.out_free, bus.req_ready);
      end
    end
  endtask

  task automatic test_link_busy();
    do_reset();
    tick(1, 8'd9, 4'b0000, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 8'd0, 4'b0010, 0);
      checks++;
      if (bus.out_free !== 17'h0) begin errors++; $display("FAIL busy_free[%0d]: got %h want 0", i, bus.out_free); end
    end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.out_free !== 17'h10009) begin errors++; $display("FAIL busy_inject: got %h want 10009", bus.out_free); end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.coll_count !== 8'd0 || bus.tx_count !== 16'd1) begin
      errors++; $display("FAIL busy_counts: got coll=%0d tx=%0d want 0/1", bus.coll_count, bus.tx_count);
    end
  endtask

  task automatic test_starvation();
    logic [16:0] want;
    do_reset();
    tick(1, 8'd77, 4'b1111, 0);
    for (int k = 1; k <= 20; k++) begin
      tick(0, 8'd0, 4'b1111, 0);
      want = (k == 17) ? 17'h1004D : 17'h0;
      checks++;
      if (bus.out_free !== want) begin errors++; $display("FAIL starve_free[%0d]: got %h want %h", k, bus.out_free, want); end
    end
    checks++;
    if (bus.coll_count !== 8'd1 || bus.tx_count !== 16'd1) begin
      errors++; $display("FAIL starve_counts: got coll=%0d tx=%0d want 1/1", bus.coll_count, bus.tx_count);
    end
  endtask

  task automatic test_bad_dest();
    do_reset();
    tick(1, 8'd144, 4'b0000, 0);
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.bad_dest !== 1'b1) begin errors++; $display("FAIL bad_pulse: got %b want 1", bus.bad_dest); end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.bad_dest !== 1'b0 || bus.out_free !== 17'h0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL bad_after: got bad=%b free=%h ready=%b want 0/0/1", bus.bad_dest, bus.out_free, bus.req_ready);
    end
    tick(1, 8'd143, 4'b0000, 0);
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.bad_dest !== 1'b0) begin errors++; $display("FAIL bad_valid143: got %b want 0", bus.bad_dest); end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.out_free !== 17'h1008F) begin errors++; $display("FAIL bad_inject143: got %h want 1008f", bus.out_free); end
  endtask

  task automatic test_gap_counters();
    logic [16:0] want;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      tick(k < 3, 8'(20 + k), 4'b0000, k < 3);
      want = (k == 2) ? 17'h10014 : (k == 5) ? 17'h10015 : (k == 8) ? 17'h10016 : 17'h0;
      checks++;
      if (bus.out_free !== want) begin errors++; $display("FAIL gap_free[%0d]: got %h want %h", k, bus.out_free, want); end
    end
    checks++;
    if (bus.tx_count !== 16'd3 || bus.rx_count !== 16'd3) begin
      errors++; $display("FAIL gap_counts: got tx=%0d rx=%0d want 3/3", bus.tx_count, bus.rx_count);
    end
    tick(1, 8'd30, 4'b0000, 1);
    tick(1, 8'd31, 4'b0000, 0);
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if (bus.out_free !== 17'h1001E) begin errors++; $display("FAIL gap_idle_rearm: got %h want 1001e", bus.out_free); end
    tick(0, 8'd0, 4'b0000, 0);
    do_reset();
    checks++;
    if (bus.out_free !== 17'h0 || bus.bad_dest !== 1'b0) begin
      errors++; $display("FAIL gap_reset_cycle: got free=%h bad=%b want 0/0", bus.out_free, bus.bad_dest);
    end
    tick(0, 8'd0, 4'b0000, 0);
    checks++;
    if ({bus.tx_count, bus.rx_count, bus.coll_count} !== 40'h0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL gap_reset_state: got tx=%0d rx=%0d coll=%0d ready=%b want 0/0/0/1",
                         bus.tx_count, bus.rx_count, bus.coll_count, bus.req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick(0, 8'd0, 4'b0000, 0);
      checks++;
      if (bus.out_free !== 17'h0) begin errors++; $display("FAIL gap_discard[%0d]: got %h want 0", k, bus.out_free); end
    end
  endtask

  task automatic test_random();
    bit v, od;
    logic [7:0] d;
    logic [3:0] l;
    int quiet;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      quiet = ((n / 150) % 2 == 1) ? 31 : 1;
      v  = bit'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 159));
      l  = ($urandom_range(0, quiet) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      od = ($urandom_range(0, 3) == 0);
      bus.router_name = 8'($urandom_range(0, 143));
      tick(v, d, l, od);
      checks++;
      if (bus.out_free !== exp_free) begin errors++; $display("FAIL rnd_free@%0d: got %h want %h", n, bus.out_free, exp_free); end
      checks++;
      if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.req_ready, exp_ready); end
      checks++;
      if (bus.bad_dest !== exp_bad) begin errors++; $display("FAIL rnd_bad@%0d: got %b want %b", n, bus.bad_dest, exp_bad); end
      checks++;
      if (bus.tx_count !== exp_tx || bus.rx_count !== exp_rx || bus.coll_count !== exp_coll) begin
        errors++; $display("FAIL rnd_counts@%0d: got tx=%0d rx=%0d coll=%0d want %0d/%0d/%0d", n,
                           bus.tx_count, bus.rx_count, bus.coll_count, exp_tx, exp_rx, exp_coll);
      end
    end
  endtask

  initial begin
    bus.router_name = 8'd5;
    bus.req_valid   = 1'b0;
    bus.req_dest    = 8'd0;
    bus.link_valid  = 4'b0000;
    bus.out_data    = 1'b0;
    model_reset();
    test_reset();
    test_single_send();
    test_fill();
    test_link_busy();
    test_starvation();
    test_bad_dest();
    test_gap_counters();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
